// File: rtl/cnna_mul_pipe.sv
// ----------------------------------------------------------------------------
// cnna_mul_pipe
//   Parametrised, pipelined multiplier for the CNN accelerator datapath.
//   Sits between the line-buffer/weight fetch stage and the accumulator tree.
//   Stage 1 captures din0*din1 (signed or unsigned), later stages copy the
//   previous one. One global advance enable drives every stage, so the
//   pipeline is a simple elastic shift register with back-pressure.
//
//   Optional feature: define CNNA_MUL_PIPE_SAT_EN to saturate dout when the
//   product does not fit dout_WIDTH (default build truncates to the LSBs).
//
// Ports
//   ap_clk      clock, rising edge
//   ap_rst      asynchronous active-high reset
//   din0/din1   operands A/B
//   din_tag     sideband returned unchanged with the product
//   din_valid   input beat valid
//   din_ready   block can accept a beat this cycle (combinational)
//   dout        product (truncated/extended, or saturated with the macro)
//   dout_tag    tag of the beat on dout
//   dout_valid  dout/dout_tag valid
//   dout_ready  downstream accepts the beat
//   busy        some pipeline stage holds a valid beat
//   ovf         sticky: an accepted product did not fit dout_WIDTH
// ----------------------------------------------------------------------------
module cnna_mul_pipe #(
  parameter int din0_WIDTH = 17,
  parameter int din1_WIDTH = 18,
  parameter int dout_WIDTH = 35,
  parameter int NUM_STAGE  = 3,
  parameter int IS_SIGNED  = 0,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [TAG_WIDTH-1:0]  din_tag,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  dout_tag,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  ovf
);

  localparam int FULL_W = din0_WIDTH + din1_WIDTH;

  logic [FULL_W-1:0]     a_ext_s;
  logic [FULL_W-1:0]     b_ext_s;
  logic [FULL_W-1:0]     prod_s;
  logic [dout_WIDTH-1:0] res_s;
  logic                  fits_s;
  logic                  adv_s;
  logic                  xfer_s;

  logic [NUM_STAGE-1:0]                 vld_q, vld_d;
  logic [NUM_STAGE-1:0][dout_WIDTH-1:0] res_q, res_d;
  logic [NUM_STAGE-1:0][TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                                 ovf_q, ovf_d;

  // Extending both operands to the full product width lets a plain
  // modular multiply give the right answer in either interpretation.
  generate
    if (IS_SIGNED != 0) begin : g_sext
      assign a_ext_s = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
      assign b_ext_s = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
    end else begin : g_zext
      assign a_ext_s = {{din1_WIDTH{1'b0}}, din0};
      assign b_ext_s = {{din0_WIDTH{1'b0}}, din1};
    end
  endgenerate

  assign prod_s = a_ext_s * b_ext_s;

  // Map the full product onto dout_WIDTH and decide whether it fits.
  generate
    if (dout_WIDTH > FULL_W) begin : g_wide
      logic ext_bit_s;
      assign ext_bit_s = (IS_SIGNED != 0) ? prod_s[FULL_W-1] : 1'b0;
      assign res_s     = {{(dout_WIDTH-FULL_W){ext_bit_s}}, prod_s};
      assign fits_s    = 1'b1;
    end else if (dout_WIDTH == FULL_W) begin : g_same
      assign res_s  = prod_s;
      assign fits_s = 1'b1;
    end else begin : g_narrow
      logic [dout_WIDTH-1:0] trunc_s;
      assign trunc_s = prod_s[dout_WIDTH-1:0];
      if (IS_SIGNED != 0) begin : g_sfit
        // Fits when every dropped bit equals the kept sign bit.
        logic [FULL_W-dout_WIDTH:0] top_s;
        assign top_s  = prod_s[FULL_W-1:dout_WIDTH-1];
        assign fits_s = (&top_s) | ~(|top_s);
      end else begin : g_ufit
        assign fits_s = ~(|prod_s[FULL_W-1:dout_WIDTH]);
      end
`ifdef CNNA_MUL_PIPE_SAT_EN
      logic [dout_WIDTH-1:0] sat_s;
      if (IS_SIGNED != 0) begin : g_ssat
        assign sat_s = prod_s[FULL_W-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                        : {1'b0, {(dout_WIDTH-1){1'b1}}};
      end else begin : g_usat
        assign sat_s = {dout_WIDTH{1'b1}};
      end
      assign res_s = fits_s ? trunc_s : sat_s;
`else
      assign res_s = trunc_s;
`endif
    end
  endgenerate

  // The whole pipe moves together: it advances whenever the output slot
  // is empty or being consumed, so bubbles are squeezed out naturally.
  assign adv_s     = ~vld_q[NUM_STAGE-1] | dout_ready;
  assign xfer_s    = din_valid & adv_s;
  assign din_ready = adv_s;

  // Next-state of the stage registers and the sticky overflow flag.
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    tag_d = tag_q;
    ovf_d = ovf_q;
    if (adv_s) begin
      vld_d[0] = xfer_s;
      // Bubbles carry zeros so ignored inputs never enter the pipe.
      res_d[0] = xfer_s ? res_s : {dout_WIDTH{1'b0}};
      tag_d[0] = xfer_s ? din_tag : {TAG_WIDTH{1'b0}};
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end else begin
      vld_d = vld_q;
      res_d = res_q;
      tag_d = tag_q;
    end
    if (xfer_s && !fits_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Stage registers and overflow flag.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_q <= '0;
      res_q <= '0;
      tag_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      tag_q <= tag_d;
      ovf_q <= ovf_d;
    end
  end

  assign dout       = res_q[NUM_STAGE-1];
  assign dout_tag   = tag_q[NUM_STAGE-1];
  assign dout_valid = vld_q[NUM_STAGE-1];
  assign busy       = |vld_q;
  assign ovf        = ovf_q;

endmodule

// File: doc/cnna_mul_pipe.md
Name: cnna_mul_pipe

Overview:
- Parametrised, pipelined multiplier for the CNN accelerator datapath.
- Successor to the fixed 17x18->35 single-stage multiplier primitives:
  - configurable operand/result widths;
  - signed or unsigned mode;
  - configurable pipeline depth;
  - valid/ready flow control with back-pressure;
  - pass-through sideband tag.
- Sits between the line-buffer/weight fetch stage and the accumulator tree.

Parameters:
- din0_WIDTH, 17, width of operand A.
- din1_WIDTH, 18, width of operand B.
- dout_WIDTH, 35, result width. Full product is din0_WIDTH+din1_WIDTH; a narrower result keeps the LSBs.
- NUM_STAGE, 3, pipeline registers from input to output. Legal range 1..8.
- IS_SIGNED, 0, selects operand interpretation: 0 = unsigned, 1 = two's complement.
- TAG_WIDTH, 8, width of the sideband tag carried alongside each product.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  reset; asynchronous, active-high.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- din_tag  in  TAG_WIDTH  sideband, returned unchanged with the result.
- din_valid  in  1  input beat valid.
- din_ready  out  1  block can accept a beat this cycle.
- dout  out  dout_WIDTH  product.
- dout_tag  out  TAG_WIDTH  tag of the beat on dout.
- dout_valid  out  1  dout/dout_tag valid.
- dout_ready  in  1  downstream accepts the beat.
- busy  out  1  any pipeline stage holds a valid beat.
- ovf  out  1  sticky: some accepted product did not fit in dout_WIDTH. Cleared only by reset.

Behaviour:
- Pipeline structure
  - NUM_STAGE stages; each stage holds {valid, product, tag}.
  - Stage 1 captures the full-width product of din0*din1. Interpretation follows IS_SIGNED; operands are sign/zero-extended.
  - Later stages copy the previous stage.
- Advance and handshake
  - Global advance enable: adv = ~dout_valid | dout_ready.
  - din_ready = adv (combinational).
  - A transfer occurs when din_valid & din_ready.
  - When adv=1, every stage shifts. Stage 1 valid takes din_valid&din_ready.
  - When adv=0, all stages hold.
  - Bubbles are carried but never presented: dout_valid = last-stage valid.
- Latency and throughput
  - Exactly NUM_STAGE cycles from accepted beat to dout_valid, with no stall.
  - Throughput 1 beat/cycle with dout_ready held high.
  - Beats are never dropped, duplicated or reordered under any dout_ready pattern.
- Output stability
  - While dout_valid=1 and dout_ready=0, dout and dout_tag are stable.
- Width rules
  - dout = product[dout_WIDTH-1:0].
  - If dout_WIDTH > full product width, the product is sign-extended (IS_SIGNED=1) or zero-extended (IS_SIGNED=0).
  - ovf sets in the cycle an accepted product differs from its own truncation, sign- or zero-extended back to full width.
- busy = OR of all stage valid bits.
- Reset values (async assert)
  - All stage valids = 0; dout_valid = 0; busy = 0; ovf = 0; dout = 0; dout_tag = 0.
  - din_ready = 1 after reset (adv=1).
- Reset mid-operation
  - In-flight beats are discarded; no dout_valid pulse for them.
  - Reset deassertion is synchronised externally; the block takes no special action.
- Simultaneous events
  - Accept at stage 1 and emit at the last stage in the same cycle is legal and is the normal streaming case.
- Invalid inputs
  - din0/din1/din_tag are ignored when din_valid=0.

Optional Feature:
- Macro: CNNA_MUL_PIPE_SAT_EN.
- Defined: dout saturates instead of truncating when the product does not fit dout_WIDTH.
  - Unsigned: clamps to all-ones.
  - Signed: clamps to max positive or min negative.
  - ovf behaviour unchanged.
- Undefined: plain LSB truncation as above; no saturation logic is synthesised.

Test Plan:
- Reset/idle: assert ap_rst mid-stream with 2 beats in flight -> dout_valid=0, busy=0, ovf=0 immediately. After release, din_ready=1 and no stale beat ever appears.
- Unsigned corner: defaults, din0=0x1FFFF, din1=0x3FFFF, tag=0xA5 -> after exactly 3 cycles dout=0x7FFFA0001, dout_tag=0xA5, ovf=0.
- Signed: IS_SIGNED=1, 8x8->16, din0=-3, din1=5 -> dout=0xFFF1 (-15). Then din0=-128, din1=-128 -> dout=0x4000.
- Back-pressure: stream 10 beats (din0=i, din1=i+1, tag=i), dout_ready random 50% -> outputs i*(i+1) in order, tags 0..9, none lost. dout is stable during every stall.
- Overflow: IS_SIGNED=0, 16x16->16, din0=300, din1=300.
  - Without macro: dout=0x5F90 (90000 mod 65536), ovf=1.
  - With CNNA_MUL_PIPE_SAT_EN: dout=0xFFFF, ovf=1.
  - IS_SIGNED=1, -300*300 with macro: dout=0x8000.
- Depth sweep: NUM_STAGE=1 and 8, continuous valid and ready -> latency 1 and 8 respectively, one result per cycle after fill.
